// File: rtl/demux2_stream.sv
// 1-to-2 stream demultiplexer: sel_i steers each accepted beat into a
// single-entry output register (A or B), with per-port handshake counters.
module demux2_stream #(
  parameter int DATA_WIDTH = 20,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sel_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] a_data_o,
  output logic                  a_valid_o,
  input  logic                  a_ready_i,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [CNT_WIDTH-1:0]  a_cnt_o,
  output logic [CNT_WIDTH-1:0]  b_cnt_o
);

  // Index 0 is port A (sel_i=1), index 1 is port B (sel_i=0).
  logic [DATA_WIDTH-1:0] r_data [2];
  logic [1:0]            r_valid;
  logic [CNT_WIDTH-1:0]  r_cnt  [2];

  logic [1:0] w_out_ready;
  logic [1:0] w_route;
  logic [1:0] w_slot_free;
  logic [1:0] w_load;
  logic [1:0] w_hs;

  assign w_out_ready = {b_ready_i, a_ready_i};
  assign w_route     = {~sel_i, sel_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign w_hs[gi]        = r_valid[gi] & w_out_ready[gi];
      // A slot can take a new beat if empty or being drained this cycle.
      assign w_slot_free[gi] = ~r_valid[gi] | w_out_ready[gi];
      assign w_load[gi]      = valid_i & w_route[gi] & w_slot_free[gi];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_data[gi]  <= '0;
          r_valid[gi] <= 1'b0;
          r_cnt[gi]   <= '0;
        end else begin
          if (w_load[gi]) begin
            r_data[gi]  <= data_i;
            r_valid[gi] <= 1'b1;
          end else if (w_hs[gi]) begin
            r_valid[gi] <= 1'b0;
          end
          if (w_hs[gi]) begin
            r_cnt[gi] <= r_cnt[gi] + CNT_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  assign ready_o   = sel_i ? w_slot_free[0] : w_slot_free[1];

  assign a_data_o  = r_data[0];
  assign a_valid_o = r_valid[0];
  assign a_cnt_o   = r_cnt[0];
  assign b_data_o  = r_data[1];
  assign b_valid_o = r_valid[1];
  assign b_cnt_o   = r_cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed scenarios plus a randomized run, all
// checked against per-port queues of accepted-but-undelivered beats.
module tb_demux2_stream;

  localparam int DW = 20;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          sel_i;
  logic          ready_o;
  logic [DW-1:0] a_data_o;
  logic          a_valid_o;
  logic          a_ready_i;
  logic [DW-1:0] b_data_o;
  logic          b_valid_o;
  logic          b_ready_i;
  logic [CW-1:0] a_cnt_o;
  logic [CW-1:0] b_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: beats accepted but not yet delivered, per port.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            cnt_a = 0;
  int            cnt_b = 0;

  demux2_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .sel_i    (sel_i),
    .ready_o  (ready_o),
    .a_data_o (a_data_o),
    .a_valid_o(a_valid_o),
    .a_ready_i(a_ready_i),
    .b_data_o (b_data_o),
    .b_valid_o(b_valid_o),
    .b_ready_i(b_ready_i),
    .a_cnt_o  (a_cnt_o),
    .b_cnt_o  (b_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic exp_ready();
    if (sel_i) return (qa.size() == 0) || a_ready_i;
    return (qb.size() == 0) || b_ready_i;
  endfunction

  // Apply inputs, then settle at the falling edge for sampling.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [DW-1:0] d, input logic ar, input logic br);
    rst_i = r; valid_i = v; sel_i = s; data_i = d;
    a_ready_i = ar; b_ready_i = br;
    @(negedge clk_i);
  endtask

  // Advance one rising edge and update the model from the pre-edge inputs.
  task automatic tick();
    logic acc, hsa, hsb, s;
    logic [DW-1:0] d;
    acc = valid_i && exp_ready();
    hsa = (qa.size() != 0) && a_ready_i;
    hsb = (qb.size() != 0) && b_ready_i;
    s   = sel_i;
    d   = data_i;
    if (rst_i) begin
      qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    end else begin
      if (hsa) begin void'(qa.pop_front()); cnt_a = (cnt_a + 1) % 256; end
      if (hsb) begin void'(qb.pop_front()); cnt_b = (cnt_b + 1) % 256; end
      if (acc) begin
        if (s) qa.push_back(d);
        else   qb.push_back(d);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 20'h00777, 0, 0); tick();
    drive(1, 1, 1, 20'h00777, 0, 0);
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_cmp++; if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got a=%b b=%b exp=0/0", a_valid_o, b_valid_o); end
    n_cmp++; if (a_cnt_o !== 8'd0 || b_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cnt got a=%0d b=%0d exp=0/0", a_cnt_o, b_cnt_o); end
    n_cmp++; if (a_data_o !== 20'd0 || b_data_o !== 20'd0) begin n_err++; $display("FAIL reset_data got a=%h b=%h exp=0/0", a_data_o, b_data_o); end
    tick();
    drive(0, 0, 0, 20'h0, 0, 0);
    n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_noload got a_valid=%b exp=0", a_valid_o); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    drive(1, 0, 0, 20'h0, 1, 1); tick();
    drive(0, 1, 1, 20'h00ABC, 1, 1);
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready got=%b exp=1", ready_o); end
    tick();
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (a_valid_o !== 1'b1 || a_data_o !== 20'h00ABC || b_valid_o !== 1'b0) begin
      n_err++; $display("FAIL basic_out got av=%b ad=%h bv=%b exp=1/00abc/0", a_valid_o, a_data_o, b_valid_o);
    end
    tick();
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (a_cnt_o !== 8'd1 || a_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_cnt got cnt=%0d av=%b exp=1/0", a_cnt_o, a_valid_o); end
    tick();
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    drive(1, 0, 0, 20'h0, 0, 0); tick();
    drive(0, 1, 1, 20'h00011, 0, 0); tick();
    drive(0, 1, 1, 20'h00022, 0, 0);
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_low got=%b exp=0", ready_o); end
    n_cmp++; if (a_data_o !== 20'h00011 || a_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_hold1 got v=%b d=%h exp=1/00011", a_valid_o, a_data_o); end
    tick();
    drive(0, 1, 1, 20'h00022, 0, 0);
    n_cmp++; if (a_data_o !== 20'h00011 || a_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_hold2 got v=%b d=%h exp=1/00011", a_valid_o, a_data_o); end
    tick();
    drive(0, 1, 1, 20'h00022, 1, 0);
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_drain got=%b exp=1", ready_o); end
    tick();
    drive(0, 0, 0, 20'h0, 1, 0);
    n_cmp++; if (a_data_o !== 20'h00022 || a_valid_o !== 1'b1 || a_cnt_o !== 8'd1) begin
      n_err++; $display("FAIL bp_second got v=%b d=%h cnt=%0d exp=1/00022/1", a_valid_o, a_data_o, a_cnt_o);
    end
    tick();
    drive(0, 0, 0, 20'h0, 1, 0);
    n_cmp++; if (a_cnt_o !== 8'd2 || a_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_cnt got cnt=%0d v=%b exp=2/0", a_cnt_o, a_valid_o); end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_independent();
    drive(1, 0, 0, 20'h0, 0, 0); tick();
    drive(0, 1, 1, 20'h00055, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 20'h00100 + DW'(i), 0, 1);
      n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL indep_ready beat=%0d got=%b exp=1", i, ready_o); end
      if (i > 0) begin
        n_cmp++; if (b_valid_o !== 1'b1 || b_data_o !== 20'h00100 + DW'(i - 1)) begin
          n_err++; $display("FAIL indep_b beat=%0d got v=%b d=%h exp=1/%h", i - 1, b_valid_o, b_data_o, 20'h00100 + DW'(i - 1));
        end
      end
      tick();
    end
    drive(0, 0, 0, 20'h0, 0, 1);
    n_cmp++; if (b_valid_o !== 1'b1 || b_data_o !== 20'h00103) begin n_err++; $display("FAIL indep_b_last got v=%b d=%h exp=1/00103", b_valid_o, b_data_o); end
    tick();
    drive(0, 0, 0, 20'h0, 0, 1);
    n_cmp++; if (b_cnt_o !== 8'd4 || b_valid_o !== 1'b0) begin n_err++; $display("FAIL indep_bcnt got cnt=%0d v=%b exp=4/0", b_cnt_o, b_valid_o); end
    n_cmp++; if (a_valid_o !== 1'b1 || a_data_o !== 20'h00055 || a_cnt_o !== 8'd0) begin
      n_err++; $display("FAIL indep_a got v=%b d=%h cnt=%0d exp=1/00055/0", a_valid_o, a_data_o, a_cnt_o);
    end
    tick();
    $display("test_independent done");
  endtask

  task automatic test_alternate();
    drive(1, 0, 0, 20'h0, 1, 1); tick();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(0, 1, (i % 2 == 0), DW'($urandom), 1, 1);
      else        drive(0, 0, 0, 20'h0, 1, 1);
      if (i < 10) begin
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL alt_ready cyc=%0d got=%b exp=1", i, ready_o); end
      end
      if (qa.size() != 0) begin
        n_cmp++; if (a_valid_o !== 1'b1 || a_data_o !== qa[0]) begin n_err++; $display("FAIL alt_a cyc=%0d got v=%b d=%h exp=1/%h", i, a_valid_o, a_data_o, qa[0]); end
      end
      if (qb.size() != 0) begin
        n_cmp++; if (b_valid_o !== 1'b1 || b_data_o !== qb[0]) begin n_err++; $display("FAIL alt_b cyc=%0d got v=%b d=%h exp=1/%h", i, b_valid_o, b_data_o, qb[0]); end
      end
      tick();
    end
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (a_cnt_o !== 8'd5 || b_cnt_o !== 8'd5) begin n_err++; $display("FAIL alt_cnt got a=%0d b=%0d exp=5/5", a_cnt_o, b_cnt_o); end
    tick();
    $display("test_alternate done");
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 20'h0, 1, 1); tick();
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, DW'(i), 1, 1);
      tick();
    end
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (b_cnt_o !== 8'd255) begin n_err++; $display("FAIL wrap_255 got=%0d exp=255", b_cnt_o); end
    tick();
    drive(0, 1, 0, 20'h12345, 1, 1);
    n_cmp++; if (b_cnt_o !== 8'd0) begin n_err++; $display("FAIL wrap_0 got=%0d exp=0", b_cnt_o); end
    tick();
    drive(0, 0, 0, 20'h0, 1, 1); tick();
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (b_cnt_o !== 8'd1 || b_cnt_o !== CW'(cnt_b)) begin n_err++; $display("FAIL wrap_1 got=%0d exp=1", b_cnt_o); end
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 20'h0, 0, 0); tick();
    drive(0, 1, 1, 20'h0AAAA, 0, 0); tick();
    drive(0, 1, 0, 20'h0BBBB, 0, 0); tick();
    drive(1, 0, 0, 20'h0, 0, 0);
    n_cmp++; if (a_valid_o !== 1'b1 || b_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_full got a=%b b=%b exp=1/1", a_valid_o, b_valid_o); end
    tick();
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid got a=%b b=%b exp=0/0", a_valid_o, b_valid_o); end
    n_cmp++; if (a_cnt_o !== 8'd0 || b_cnt_o !== 8'd0) begin n_err++; $display("FAIL rmid_cnt got a=%0d b=%0d exp=0/0", a_cnt_o, b_cnt_o); end
    tick();
    drive(0, 0, 0, 20'h0, 1, 1);
    n_cmp++; if (a_valid_o !== 1'b0 || b_valid_o !== 1'b0 || a_cnt_o !== 8'd0 || b_cnt_o !== 8'd0) begin
      n_err++; $display("FAIL rmid_stale got av=%b bv=%b ac=%0d bc=%0d exp=0/0/0/0", a_valid_o, b_valid_o, a_cnt_o, b_cnt_o);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    drive(1, 0, 0, 20'h0, 0, 0); tick();
    for (int i = 0; i < 400; i++) begin
      drive(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), DW'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      n_cmp++; if (ready_o !== exp_ready()) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, ready_o, exp_ready()); end
      n_cmp++; if (a_valid_o !== (qa.size() != 0) || b_valid_o !== (qb.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid cyc=%0d got a=%b b=%b exp=%0d/%0d", i, a_valid_o, b_valid_o, qa.size(), qb.size());
      end
      if (qa.size() != 0) begin
        n_cmp++; if (a_data_o !== qa[0]) begin n_err++; $display("FAIL rnd_adata cyc=%0d got=%h exp=%h", i, a_data_o, qa[0]); end
      end
      if (qb.size() != 0) begin
        n_cmp++; if (b_data_o !== qb[0]) begin n_err++; $display("FAIL rnd_bdata cyc=%0d got=%h exp=%h", i, b_data_o, qb[0]); end
      end
      n_cmp++; if (a_cnt_o !== CW'(cnt_a) || b_cnt_o !== CW'(cnt_b)) begin
        n_err++; $display("FAIL rnd_cnt cyc=%0d got a=%0d b=%0d exp=%0d/%0d", i, a_cnt_o, b_cnt_o, cnt_a, cnt_b);
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; sel_i = 1'b0; data_i = '0;
    a_ready_i = 1'b0; b_ready_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_independent();
    test_alternate();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, width of every data port.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each per-output transfer counter.
REQ-003 SHALL have one clock and a synchronous active-high reset; port list follows.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 data_i  input  DATA_WIDTH  input beat.
REQ-007 valid_i  input  1  data_i/sel_i valid.
REQ-008 sel_i  input  1  route select: 1 -> port A, 0 -> port B; qualified by valid_i.
REQ-009 ready_o  output  1  input beat accepted when valid_i && ready_o.
REQ-010 a_data_o  output  DATA_WIDTH  port A beat.
REQ-011 a_valid_o  output  1  port A beat valid.
REQ-012 a_ready_i  input  1  port A consumer ready.
REQ-013 b_data_o  output  DATA_WIDTH  port B beat.
REQ-014 b_valid_o  output  1  port B beat valid.
REQ-015 b_ready_i  input  1  port B consumer ready.
REQ-016 a_cnt_o  output  CNT_WIDTH  completed port A transfers.
REQ-017 b_cnt_o  output  CNT_WIDTH  completed port B transfers.

Function
REQ-018 SHALL hold one independent single-entry register (data + valid flag) per output port.
REQ-019 SHALL drive a_data_o/a_valid_o and b_data_o/b_valid_o directly from those registers (no combinational path from data_i).
REQ-020 SHALL compute ready_o combinationally: sel_i=1 -> (!a_valid_o || a_ready_i); sel_i=0 -> (!b_valid_o || b_ready_i).
REQ-021 SHALL, on accept with sel_i=1, load data_i into register A and set a_valid_o next cycle; register B unchanged.
REQ-022 SHALL, on accept with sel_i=0, load data_i into register B and set b_valid_o next cycle; register A unchanged.
REQ-023 SHALL provide input-to-output latency of exactly 1 cycle.
REQ-024 SHALL clear a port's valid flag after a handshake (valid && ready) on that port unless a new beat for that port is accepted in the same cycle.
REQ-025 SHALL, on same-cycle drain and accept on one port, keep valid high and present the new beat next cycle (full throughput, one beat/cycle per port).
REQ-026 SHALL keep a port's data and valid stable while valid is high and its ready is low.
REQ-027 SHALL let ports A and B drain independently and simultaneously; a stall on one port SHALL NOT block accepts routed to the other.
REQ-028 SHALL ignore data_i and sel_i when valid_i is low; no state change.
REQ-029 SHALL increment a_cnt_o on each port A handshake and b_cnt_o on each port B handshake.
REQ-030 SHALL wrap counters modulo 2^CNT_WIDTH (all-ones + 1 -> 0), no saturation.
REQ-031 SHALL not drop, duplicate or reorder beats within one port; relative order across ports is not preserved.

Reset
REQ-032 SHALL, while rst_i high at a clock edge, clear a_valid_o, b_valid_o, a_cnt_o, b_cnt_o to 0 and data registers to 0.
REQ-033 SHALL discard any beat held in either register when reset asserts mid-operation; no handshake counted that cycle.
REQ-034 SHALL drive ready_o per REQ-020 during reset (both valid flags 0 after first reset edge -> ready_o = 1) but SHALL NOT load beats while rst_i is high.

Verification
REQ-035 Reset then valid_i=1, sel_i=1, data_i=0x00ABC, a_ready_i=1 -> next cycle a_valid_o=1, a_data_o=0x00ABC, b_valid_o=0; following cycle a_cnt_o=1.
REQ-036 a_ready_i=0, send beat 0x00011 to A, then a second A beat -> ready_o=0 for second beat, a_data_o held at 0x00011 until a_ready_i=1, then 0x00022 next cycle.
REQ-037 A stalled (a_ready_i=0, a_valid_o=1), stream 4 beats sel_i=0 with b_ready_i=1 -> all 4 appear on B on consecutive cycles, b_cnt_o=4, A unchanged.
REQ-038 Both readies high, alternate sel_i 1/0 each cycle for 10 beats -> ready_o constantly 1, a_cnt_o=5, b_cnt_o=5, per-port order matches input.
REQ-039 CNT_WIDTH=8, 256 port-B handshakes -> b_cnt_o wraps to 0; one more -> 1.
REQ-040 Assert rst_i for one cycle with both registers full and readies low -> a_valid_o=b_valid_o=0, counters 0, no stale beat delivered afterwards.
